// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down FSM counter.
// State encoding is fixed at 2 bits so the debug port width never changes.
package counter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_SAT  = 2'b11
    } state_t;

endpackage : counter_pkg

// File: rtl/counter_step_calc.sv
// Combinational next-value calculation for one enabled step of the counter.
// Bounds are 0 and MAX_VAL, so non-power-of-2 moduli wrap correctly.
module counter_step_calc #(
    parameter int          WIDTH   = 3,
    parameter int unsigned MAX_VAL = 2**WIDTH-1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] next_count,
    output logic             at_bound
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        next_count = count;
        at_bound   = up_dn ? (count == MAX_W) : (count == '0);
        if (at_bound) begin
            if (!sat_mode) begin
                next_count = up_dn ? '0 : MAX_W;
            end
        end else begin
            next_count = up_dn ? count + 1'b1 : count - 1'b1;
        end
    end

endmodule : counter_step_calc

// File: rtl/counter_updown_param_fsm.sv
// Parametrised up/down counter with FSM direction control, parallel load,
// wrap/saturate selection and a registered terminal-count pulse.
module counter_updown_param_fsm
    import counter_pkg::*;
#(
    parameter int          WIDTH   = 3,
    parameter int unsigned MAX_VAL = 2**WIDTH-1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               up_dn,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               sat_mode,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic [STATE_W-1:0] state
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    state_t           r_state;

    logic [WIDTH-1:0] w_next_count;
    logic             w_at_bound;
    logic [WIDTH-1:0] w_load_clamped;

    counter_step_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_step_calc (
        .count      (r_count),
        .up_dn      (up_dn),
        .sat_mode   (sat_mode),
        .next_count (w_next_count),
        .at_bound   (w_at_bound)
    );

    assign w_load_clamped = (load_val > MAX_W) ? MAX_W : load_val;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_state <= ST_IDLE;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_tc    <= 1'b0;
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_UP, ST_DOWN, ST_SAT: begin
                    if (!en) begin
                        r_tc    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= w_next_count;
                        if (w_at_bound && sat_mode) begin
                            // Pulse only on the edge that enters SAT.
                            r_tc    <= (r_state != ST_SAT);
                            r_state <= ST_SAT;
                        end else begin
                            r_tc    <= w_at_bound;
                            r_state <= up_dn ? ST_UP : ST_DOWN;
                        end
                    end
                end
                default: begin
                    r_tc    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign state = r_state;

endmodule : counter_updown_param_fsm

// File: tb/tb_counter_updown_param_fsm.sv
// Directed bench for counter_updown_param_fsm: one instance with MAX_VAL=7,
// one with MAX_VAL=5, sharing the same input stimulus.
module tb_counter_updown_param_fsm;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [2:0] load_val;
    logic       sat_mode;

    logic [2:0] count7, count5;
    logic       tc7, tc5;
    logic [1:0] state7, state5;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_UP   = 2'b01;
    localparam logic [1:0] S_DOWN = 2'b10;
    localparam logic [1:0] S_SAT  = 2'b11;

    counter_updown_param_fsm #(.WIDTH(3), .MAX_VAL(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .sat_mode(sat_mode),
        .count(count7), .tc(tc7), .state(state7)
    );

    counter_updown_param_fsm #(.WIDTH(3), .MAX_VAL(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .sat_mode(sat_mode),
        .count(count5), .tc(tc5), .state(state5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0; sat_mode = 1'b0;
        tick(); tick();
        chk("reset_count7", 0, count7, 3'd0);
        chk("reset_tc7",    0, {2'b0, tc7}, 3'd0);
        chk("reset_state7", 0, {1'b0, state7}, {1'b0, S_IDLE});
        chk("reset_count5", 0, count5, 3'd0);
    endtask

    task automatic test_up_wrap();
        int exp_cnt [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        rst_n = 1'b1; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("up_count", i, count7, 3'(exp_cnt[i]));
            chk("up_tc",    i, {2'b0, tc7}, (i == 7) ? 3'd1 : 3'd0);
            chk("up_state", i, {1'b0, state7}, {1'b0, S_UP});
        end
    endtask

    task automatic test_down_wrap_mod5();
        int exp_cnt [3] = '{5, 4, 3};
        load = 1'b1; load_val = 3'd0; en = 1'b0;
        tick();
        chk("mod5_load", 0, count5, 3'd0);
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mod5_down_count", i, count5, 3'(exp_cnt[i]));
            chk("mod5_down_tc",    i, {2'b0, tc5}, (i == 0) ? 3'd1 : 3'd0);
            chk("mod5_down_state", i, {1'b0, state5}, {1'b0, S_DOWN});
        end
        // Up from MAX_VAL=5 must wrap to 0, not continue to 6.
        load = 1'b1; load_val = 3'd5; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick();
        chk("mod5_up_wrap_count", 0, count5, 3'd0);
        chk("mod5_up_wrap_tc",    0, {2'b0, tc5}, 3'd1);
    endtask

    task automatic test_saturate();
        logic [1:0] exp_st [4] = '{S_UP, S_SAT, S_SAT, S_SAT};
        sat_mode = 1'b1; load = 1'b1; load_val = 3'd6; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sat_count", i, count7, 3'd7);
            chk("sat_state", i, {1'b0, state7}, {1'b0, exp_st[i]});
            chk("sat_tc",    i, {2'b0, tc7}, (i == 1) ? 3'd1 : 3'd0);
        end
        up_dn = 1'b0;
        tick();
        chk("sat_exit_count", 0, count7, 3'd6);
        chk("sat_exit_state", 0, {1'b0, state7}, {1'b0, S_DOWN});
        chk("sat_exit_tc",    0, {2'b0, tc7}, 3'd0);
        // Saturate at the low bound on the MAX_VAL=5 instance.
        load = 1'b1; load_val = 3'd0; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        tick();
        chk("sat_low_count", 0, count5, 3'd0);
        chk("sat_low_state", 0, {1'b0, state5}, {1'b0, S_SAT});
        chk("sat_low_tc",    0, {2'b0, tc5}, 3'd1);
        tick();
        chk("sat_low_hold_tc", 0, {2'b0, tc5}, 3'd0);
        sat_mode = 1'b0;
    endtask

    task automatic test_priority();
        load = 1'b1; load_val = 3'd7; en = 1'b1; up_dn = 1'b1;
        tick();
        chk("prio_clamp_count5", 0, count5, 3'd5);
        chk("prio_clamp_state5", 0, {1'b0, state5}, {1'b0, S_IDLE});
        chk("prio_count7",       0, count7, 3'd7);
        chk("prio_tc5",          0, {2'b0, tc5}, 3'd0);
        rst_n = 1'b0;
        tick();
        chk("prio_rst_count7", 0, count7, 3'd0);
        chk("prio_rst_count5", 0, count5, 3'd0);
        chk("prio_rst_tc7",    0, {2'b0, tc7}, 3'd0);
        rst_n = 1'b1; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_direction_flip();
        load = 1'b1; load_val = 3'd2; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick();
        chk("flip_up_count", 0, count7, 3'd3);
        chk("flip_up_state", 0, {1'b0, state7}, {1'b0, S_UP});
        up_dn = 1'b0;
        tick();
        chk("flip_down_count", 0, count7, 3'd2);
        chk("flip_down_state", 0, {1'b0, state7}, {1'b0, S_DOWN});
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("gap_count", i, count7, 3'd2);
            chk("gap_state", i, {1'b0, state7}, {1'b0, S_IDLE});
        end
    endtask

    task automatic test_mid_reset();
        sat_mode = 1'b0; load = 1'b1; load_val = 3'd6; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick();
        chk("mid_pre_count", 0, count7, 3'd7);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_count", 0, count7, 3'd0);
        chk("mid_rst_tc",    0, {2'b0, tc7}, 3'd0);
        chk("mid_rst_state", 0, {1'b0, state7}, {1'b0, S_IDLE});
        rst_n = 1'b1; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap_mod5();
        test_saturate();
        test_priority();
        test_direction_flip();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_counter_updown_param_fsm
